// File: rtl/load_store_unit.sv
// load_store_unit: memory stage issuing one data-bus transaction per LOAD/STORE instruction.
// Ports: clk, reset (async, active-high); core side start/instruction/addr/store_data in,
// busy/done/fault/load_data out; bus side mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata out,
// mem_rdata/mem_ack in.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of issuing them.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  logic [1:0]  state_q, state_d, lane_q, lane_d, size;
  logic [2:0]  funct3_q, funct3_d, f3;
  logic        fault_q, fault_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, load_data_q, load_data_d;
  logic [31:0] ld_ext, st_data;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d, st_strb;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        is_ld, is_st, accept, misaligned, unused;
  assign unused = ^{instruction[31:15], instruction[11:7]};
  assign f3 = instruction[14:12];
  assign is_ld = instruction[6:0] == OP_LOAD;
  assign is_st = instruction[6:0] == OP_STORE;
  assign accept = (state_q == IDLE) && start && (is_ld || is_st);
  // size: 0 byte, 1 half, 2 word; store funct3 100 is a word store, load funct3 100 is LBU
  assign size = is_st ? (f3 == 3'b000 ? 2'd0 : f3 == 3'b001 ? 2'd1 : 2'd2)
                      : (f3[1:0] == 2'b00 ? 2'd0 : f3[1:0] == 2'b01 ? 2'd1 : 2'd2);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  assign st_strb = size == 2'd0 ? 4'b0001 << addr[1:0] : size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_data = size == 2'd0 ? {4{store_data[7:0]}} : size == 2'd1 ? {2{store_data[15:0]}} : store_data;
  assign rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
  assign rd_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  // funct3[2] selects zero-extension for LBU/LHU
  assign ld_ext = funct3_q[1:0] == 2'b00 ? {{24{~funct3_q[2] & rd_byte[7]}}, rd_byte}
                : funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & rd_half[15]}}, rd_half}
                : mem_rdata;
  always_comb begin
    state_d = state_q;
    funct3_d = funct3_q;
    lane_d = lane_q;
    fault_d = fault_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;
    if (accept) begin
      funct3_d = f3;
      lane_d = addr[1:0];
      fault_d = misaligned;
      mem_we_d = is_st;
      mem_addr_d = {addr[31:2], 2'b00};
      mem_wstrb_d = is_st ? st_strb : 4'b0000;
      mem_wdata_d = st_data;
      load_data_d = (misaligned && is_ld) ? 32'h0 : load_data_q;
      state_d = misaligned ? DONE : REQ;
    end
    if (state_q == REQ && mem_ack) begin
      load_data_d = mem_we_q ? load_data_q : ld_ext;
      state_d = DONE;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      funct3_q <= 3'b000;
      lane_q <= 2'b00;
      fault_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= 32'h0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= 32'h0;
      load_data_q <= 32'h0;
    end else begin
      state_q <= state_d;
      funct3_q <= funct3_d;
      lane_q <= lane_d;
      fault_q <= fault_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
    end
  end
  // mem_req and busy decode the state directly so reset drops them without waiting for a clock
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign mem_req = state_q == REQ;
  assign fault = done && fault_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
  assign load_data = load_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus against a spec-level model of the load/store unit.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset, start, mem_ack;
  logic [31:0] instruction, addr, store_data, mem_rdata;
  logic busy, done, fault, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  int checks = 0, errors = 0;
  logic cmp_en = 1'b0;
  logic e_busy, e_done, e_fault, e_req, e_we, e_zero;
  logic [31:0] e_addr, e_wdata, e_load, e_lit;
  logic [3:0] e_wstrb;
  int lit_sel;
  event probe;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [31:0] LW_MIS_LIT = 32'h0;
`else
  localparam logic [31:0] LW_MIS_LIT = 32'hCAFEF00D;
`endif
  always #5 clk = ~clk;
  load_store_unit dut (
    .clk(clk), .reset(reset), .start(start), .instruction(instruction), .addr(addr),
    .store_data(store_data), .busy(busy), .done(done), .fault(fault), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  function automatic int size_of(bit st, logic [2:0] f3);
    if (st) return f3 == 3'd0 ? 0 : f3 == 3'd1 ? 1 : 2;
    return f3[1:0] == 2'd0 ? 0 : f3[1:0] == 2'd1 ? 1 : 2;
  endfunction
  function automatic logic [3:0] m_strb(int sz, logic [31:0] a);
    if (sz == 0) return 4'(1 << a[1:0]);
    if (sz == 1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction
  function automatic logic [31:0] m_wdata(int sz, logic [31:0] d);
    if (sz == 0) return {24'h0, d[7:0]} * 32'h01010101;
    if (sz == 1) return {16'h0, d[15:0]} * 32'h00010001;
    return d;
  endfunction
  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    int sz;
    logic [31:0] v;
    sz = size_of(1'b0, f3);
    if (sz == 2) return rd;
    if (sz == 0) begin
      v = (rd >> (8 * a[1:0])) & 32'hFF;
      if (!f3[2] && v[7]) v = v - 32'h100;
    end else begin
      v = (rd >> (16 * a[1])) & 32'hFFFF;
      if (!f3[2] && v[15]) v = v - 32'h10000;
    end
    return v;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic compare();
    chk("busy", {31'h0, busy}, {31'h0, e_busy});
    chk("done", {31'h0, done}, {31'h0, e_done});
    chk("fault", {31'h0, fault}, {31'h0, e_fault});
    chk("mem_req", {31'h0, mem_req}, {31'h0, e_req});
    chk("load_data", load_data, e_load);
    if (e_req) begin
      chk("mem_we", {31'h0, mem_we}, {31'h0, e_we});
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, e_wstrb});
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
    if (e_zero) begin
      chk("rst_we", {31'h0, mem_we}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
    end
    if (lit_sel == 1) chk("lit_load", load_data, e_lit);
    if (lit_sel == 2) chk("lit_wdata", mem_wdata, e_lit);
  endtask
  always begin
    @(negedge clk or probe);
    if (cmp_en) compare();
  end
  function automatic logic [31:0] enc(bit st, logic [2:0] f3);
    return {17'h0, f3, 5'h0, st ? 7'b0100011 : 7'b0000011};
  endfunction
  task automatic idle_exp();
    e_busy = 0; e_done = 0; e_fault = 0; e_req = 0; lit_sel = 0;
  endtask
  task automatic txn(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] sd, logic [31:0] rd,
                     int d, bit poke, int ls, logic [31:0] lit);
    int sz;
    bit trap;
    sz = size_of(st, f3);
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (a % (32'd1 << sz)) != 0;
`else
    trap = 0;
`endif
    instruction = enc(st, f3); addr = a; store_data = sd; start = 1;
    idle_exp();
    @(posedge clk); #1;
    start = 0; e_zero = 0;
    if (!trap) begin
      for (int i = 0; i <= d; i++) begin
        e_busy = 1; e_req = 1; e_we = st; e_addr = {a[31:2], 2'b00};
        e_wstrb = st ? m_strb(sz, a) : 4'h0; e_wdata = m_wdata(sz, sd);
        lit_sel = (ls == 2) ? 2 : 0; e_lit = lit;
        if (poke && i == 0) begin
          start = 1; instruction = enc(1'b0, 3'b000); addr = a ^ 32'h100;
        end
        mem_ack = (i == d); mem_rdata = (i == d) ? rd : 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_ack = 0; start = 0; instruction = enc(st, f3); addr = a;
      end
    end
    e_req = 0; e_busy = 1; e_done = 1; e_fault = trap;
    if (!st) e_load = trap ? 32'h0 : m_load(f3, a, rd);
    lit_sel = (ls == 1) ? 1 : 0; e_lit = lit;
    @(posedge clk); #1;
    idle_exp();
  endtask
  initial begin
    reset = 0; start = 0; mem_ack = 0; instruction = 0; addr = 0; store_data = 0; mem_rdata = 0;
    idle_exp(); e_we = 0; e_zero = 1; e_addr = 0; e_wdata = 0; e_wstrb = 0; e_load = 0; e_lit = 0;
    #2 reset = 1; cmp_en = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    txn(1, 3'b000, 32'h00001003, 32'h000000A5, 32'h0, 2, 0, 2, 32'hA5A5A5A5);
    txn(0, 3'b000, 32'h00002001, 32'h0, 32'h1234F678, 1, 0, 1, 32'hFFFFFFF6);
    txn(0, 3'b100, 32'h00002001, 32'h0, 32'h1234F678, 1, 0, 1, 32'h000000F6);
    txn(0, 3'b001, 32'h00002002, 32'h0, 32'h80017FFF, 1, 0, 1, 32'hFFFF8001);
    txn(0, 3'b010, 32'h00002004, 32'h0, 32'h13579BDF, 0, 0, 1, 32'h13579BDF);
    txn(1, 3'b001, 32'h00004002, 32'h1234BEEF, 32'h0, 1, 0, 2, 32'hBEEFBEEF);
    txn(1, 3'b010, 32'h00004000, 32'h89ABCDEF, 32'h0, 0, 0, 2, 32'h89ABCDEF);
    txn(0, 3'b101, 32'h00002000, 32'h0, 32'h80017FFF, 2, 0, 1, 32'h00007FFF);
    txn(0, 3'b010, 32'h00003002, 32'h0, 32'hCAFEF00D, 1, 0, 1, LW_MIS_LIT);
    txn(1, 3'b001, 32'h00004001, 32'h00005A5A, 32'h0, 1, 0, 0, 32'h0);
    txn(0, 3'b000, 32'h00005003, 32'h0, 32'h7F000000, 3, 1, 1, 32'h0000007F);
    txn(1, 3'b000, 32'h00005000, 32'h00000011, 32'h0, 0, 0, 0, 32'h0);
    // non-memory opcode must be ignored
    instruction = {17'h0, 3'b010, 5'h0, 7'b0110011}; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    // reset while waiting for ack, then a late ack
    instruction = enc(1'b0, 3'b010); addr = 32'h00006000; start = 1;
    @(posedge clk); #1;
    start = 0; e_busy = 1; e_req = 1; e_we = 0; e_addr = 32'h00006000; e_wstrb = 4'h0;
    @(negedge clk); #1;
    reset = 1; #1;
    idle_exp(); e_load = 0; e_zero = 1; ->probe;
    @(posedge clk); #1;
    reset = 0; mem_ack = 1; mem_rdata = 32'h55555555;
    repeat (3) @(posedge clk);
    #1 mem_ack = 0;
    @(posedge clk); #1;
    txn(0, 3'b000, 32'h00007002, 32'h0, 32'h00800000, 1, 0, 1, 32'hFFFFFF80);
    @(posedge clk); #1;
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
